uart_tx_arbiter: RTL

Shares the single UART transmitter between N_REQ byte producers (master control acknowledge path, result sender, status reporter). Round-robin arbitration with optional grant lock for multi-byte packets. Drives the UART start strobe and data byte, and tracks the UART busy handshake through a bounded timeout. Sits between the requesters and the UART TX, replacing the per-source UART source muxes.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N_REQ byte producers
module uart_tx_arbiter #(
  parameter int N_REQ   = 3,
  parameter int BUSY_TO = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [8*N_REQ-1:0] tx_data,
  input  logic               uart_busy,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   byte_done,
  output logic               start_uart_tx,
  output logic [7:0]         uart_data,
  output logic               arb_busy,
  output logic               err_timeout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(BUSY_TO - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     owner, owner_nxt;
  logic [IW-1:0]     last_winner, last_winner_nxt;
  logic [7:0]        timer, timer_nxt;
  logic [N_REQ-1:0]  grant_nxt, byte_done_nxt;
  logic              start_nxt, err_nxt, arb_busy_nxt;
  logic [7:0]        data_nxt;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [7:0]        win_byte, own_byte;
  int                cand;

  // round-robin search starting just after the previous winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_winner) + k) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign win_byte = tx_data[{win_idx, 3'b000} +: 8];
  assign own_byte = tx_data[{owner, 3'b000} +: 8];

  // next-state and next-output decode; every output is registered from these
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_winner_nxt = last_winner;
    timer_nxt       = timer;
    grant_nxt       = grant;
    data_nxt        = uart_data;
    byte_done_nxt   = '0;
    start_nxt       = 1'b0;
    err_nxt         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found && !uart_busy) begin
          owner_nxt          = win_idx;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          data_nxt           = win_byte;
          start_nxt          = 1'b1;
          state_nxt          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_nxt = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer == TO_LAST) begin
          byte_done_nxt = grant;
          state_nxt     = ST_DONE;
        end else begin
          timer_nxt = timer + 8'd1;
          // flag lands in the final waiting cycle so byte_done follows directly
          err_nxt   = ((timer + 8'd1) == TO_LAST);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          byte_done_nxt = grant;
          state_nxt     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (lock[owner] && req[owner]) begin
          data_nxt  = own_byte;
          start_nxt = 1'b1;
          state_nxt = ST_LAUNCH;
        end else begin
          grant_nxt       = '0;
          last_winner_nxt = owner;
          state_nxt       = ST_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
    arb_busy_nxt = (state_nxt != ST_IDLE);
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      owner         <= '0;
      last_winner   <= LAST_REQ;
      timer         <= '0;
      grant         <= '0;
      byte_done     <= '0;
      start_uart_tx <= 1'b0;
      uart_data     <= 8'h00;
      arb_busy      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      last_winner   <= last_winner_nxt;
      timer         <= timer_nxt;
      grant         <= grant_nxt;
      byte_done     <= byte_done_nxt;
      start_uart_tx <= start_nxt;
      uart_data     <= data_nxt;
      arb_busy      <= arb_busy_nxt;
      err_timeout   <= err_nxt;
    end
  end

endmodule
